// File: rtl/mul_req_arbiter.sv
// mul_req_arbiter: shares one iterative signed multiplier between NREQ requesters.
// Round-robin grant in IDLE, operand capture, one-cycle load pulse, wait for the
// multiplier's done pulse, then a tagged valid/ready response.
// Optional build macro: MULARB_TIMEOUT_EN adds a WAIT-state watchdog that returns
// rsp_err=1 with a zero product after TIMEOUT cycles without mul_done.
module mul_req_arbiter #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_m,
  input  logic [NREQ*WIDTH-1:0]   req_q,
  output logic                    mul_load,
  output logic [WIDTH-1:0]        mul_m,
  output logic [WIDTH-1:0]        mul_q,
  input  logic                    mul_done,
  input  logic [2*WIDTH-1:0]      mul_p,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]      rsp_p,
  output logic                    rsp_err,
  output logic                    busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       last_grant_q;
  logic [IDW-1:0]       grant_idx;
  logic [IDW-1:0]       cand_idx;
  logic                 grant_found;
  logic                 handshake;
  logic                 timeout_hit;
  logic [WIDTH-1:0]     mul_m_q, mul_q_q;
  logic [IDW-1:0]       rsp_id_q;
  logic [2*WIDTH-1:0]   rsp_p_q;

  // Rotating-priority search: start one past the last winner and wrap.
  // IDW-bit addition wraps for free because NREQ is a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand_idx    = last_grant_q;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand_idx = last_grant_q + IDW'(off);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign handshake = (state_q == StIdle) && grant_found;

  // Grant is offered only in IDLE; forced low while reset is held.
  always_comb begin
    req_ready = '0;
    if (handshake && !reset) begin
      req_ready = NREQ'(1) << grant_idx;
    end
  end

`ifdef MULARB_TIMEOUT_EN
  localparam int unsigned TmrW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TmrW-1:0] timer_q;
  logic            rsp_err_q;

  // Counts WAIT cycles; zeroed in ISSUE so the first WAIT cycle sees 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (state_q == StIssue) begin
      timer_q <= '0;
    end else if (state_q == StWait) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Expires at the end of the TIMEOUT-th WAIT cycle; a coincident done wins.
  assign timeout_hit = (state_q == StWait) && !mul_done && (timer_q == TmrW'(TIMEOUT - 1));

  // Error flag is captured together with the response payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_err_q <= 1'b0;
    end else if (state_q == StWait) begin
      if (mul_done) begin
        rsp_err_q <= 1'b0;
      end else if (timeout_hit) begin
        rsp_err_q <= 1'b1;
      end
    end
  end

  assign rsp_err = rsp_err_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  // Next-state logic for the IDLE -> ISSUE -> WAIT -> RESP loop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (handshake) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (mul_done || timeout_hit) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand/ID capture on grant; product capture on done (or zero on timeout).
  // mul_m/mul_q are deliberately left holding their values after ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= IDW'(NREQ - 1);
      mul_m_q      <= '0;
      mul_q_q      <= '0;
      rsp_id_q     <= '0;
      rsp_p_q      <= '0;
    end else begin
      if (handshake) begin
        mul_m_q      <= req_m[grant_idx*WIDTH +: WIDTH];
        mul_q_q      <= req_q[grant_idx*WIDTH +: WIDTH];
        rsp_id_q     <= grant_idx;
        last_grant_q <= grant_idx;
      end
      if (state_q == StWait) begin
        if (mul_done) begin
          rsp_p_q <= mul_p;
        end else if (timeout_hit) begin
          rsp_p_q <= '0;
        end
      end
    end
  end

  // Outputs decoded from state; all are zero in IDLE, hence zero on reset.
  always_comb begin
    mul_load  = (state_q == StIssue);
    rsp_valid = (state_q == StResp);
    busy      = (state_q != StIdle);
  end

  assign mul_m  = mul_m_q;
  assign mul_q  = mul_q_q;
  assign rsp_id = rsp_id_q;
  assign rsp_p  = rsp_p_q;

endmodule
